// File: rtl/if_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_pkg : trap vectors, fetch FSM states and redirect kinds for if_stage
// Revision 1.0
// ---------------------------------------------------------------------------
package if_pkg;

  localparam logic [31:0] IF_RESET_VECTOR = 32'h8000_0000;
  localparam logic [31:0] IF_ILLOP_VECTOR = 32'h8000_0004;
  localparam logic [31:0] IF_XADR_VECTOR  = 32'h8000_0008;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } if_state_e;

  typedef enum logic [2:0] {
    RD_NONE   = 3'd0,
    RD_JUMP   = 3'd1,
    RD_BRANCH = 3'd2,
    RD_INTR   = 3'd3,
    RD_EXC    = 3'd4
  } redir_kind_e;

  function automatic logic is_trap(input redir_kind_e kind);
    return (kind == RD_INTR) || (kind == RD_EXC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_pc_redirect_sel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_redirect_sel : prioritises trap/branch/jump redirects and aligns target
// Revision 1.0
// ---------------------------------------------------------------------------
module pc_redirect_sel
  import if_pkg::*;
#(
  parameter logic [31:0] ILLOP_VECTOR = IF_ILLOP_VECTOR,
  parameter logic [31:0] XADR_VECTOR  = IF_XADR_VECTOR
) (
  input  logic        pc_kernel_i,
  input  logic        exception_i,
  input  logic        interrupt_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic        valid_o,
  output redir_kind_e kind_o,
  output logic [31:0] target_o
);

  logic [31:0] raw_target;

  always_comb begin
    kind_o     = RD_NONE;
    raw_target = 32'h0;
    // Interrupts are masked while already executing in kernel space.
    if (exception_i) begin
      kind_o     = RD_EXC;
      raw_target = XADR_VECTOR;
    end else if (interrupt_i && !pc_kernel_i) begin
      kind_o     = RD_INTR;
      raw_target = ILLOP_VECTOR;
    end else if (branch_taken_i) begin
      kind_o     = RD_BRANCH;
      raw_target = branch_target_i;
    end else if (jump_i) begin
      kind_o     = RD_JUMP;
      raw_target = jump_target_i;
    end
  end

  assign valid_o  = (kind_o != RD_NONE);
  assign target_o = {raw_target[31:2], 2'b00};

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_stage : instruction fetch with redirect handling and wrong-path discard
// Revision 1.0
// ---------------------------------------------------------------------------
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = IF_RESET_VECTOR,
  parameter logic [31:0] ILLOP_VECTOR = IF_ILLOP_VECTOR,
  parameter logic [31:0] XADR_VECTOR  = IF_XADR_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_Stall,
  input  logic        Jump,
  input  logic [31:0] Jump_Target,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic        Interrupt,
  input  logic        Exception,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ready,
  input  logic [31:0] Imem_Rdata,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_Instruction,
  output logic        IF_Valid,
  output logic        IF_Busy,
  output logic [31:0] PC
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  redir_kind_e pend_kind_q, pend_kind_d;

  logic        transfer;
  logic        sel_valid;
  redir_kind_e sel_kind;
  logic [31:0] sel_target;
  logic        new_wins;
  logic [31:0] pc_seq;

  pc_redirect_sel #(
    .ILLOP_VECTOR (ILLOP_VECTOR),
    .XADR_VECTOR  (XADR_VECTOR)
  ) u_sel (
    .pc_kernel_i     (pc_q[31]),
    .exception_i     (Exception),
    .interrupt_i     (Interrupt),
    .branch_taken_i  (Branch_Taken),
    .branch_target_i (Branch_Target),
    .jump_i          (Jump),
    .jump_target_i   (Jump_Target),
    .valid_o         (sel_valid),
    .kind_o          (sel_kind),
    .target_o        (sel_target)
  );

  assign transfer = Imem_Req & Imem_Ready;
  // Privilege bit is sticky across sequential fetch; only the low 31 bits wrap.
  assign pc_seq   = {pc_q[31], pc_q[30:0] + 31'd4};
  // A pending trap target may only be replaced by another trap.
  assign new_wins = sel_valid & ~(is_trap(pend_kind_q) & ~is_trap(sel_kind));

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_tgt_d  = pend_tgt_q;
    pend_kind_d = pend_kind_q;
    case (state_q)
      FETCH: begin
        if (transfer) begin
          if (sel_valid)      pc_d = sel_target;
          else if (!PC_Stall) pc_d = pc_seq;
        end else if (sel_valid) begin
          pend_tgt_d  = sel_target;
          pend_kind_d = sel_kind;
          state_d     = DISCARD;
        end
      end
      DISCARD: begin
        if (transfer) begin
          pc_d        = new_wins ? sel_target : pend_tgt_q;
          pend_kind_d = RD_NONE;
          state_d     = FETCH;
        end else if (new_wins) begin
          pend_tgt_d  = sel_target;
          pend_kind_d = sel_kind;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_VECTOR;
      pend_tgt_q  <= 32'h0;
      pend_kind_q <= RD_NONE;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_kind_q <= pend_kind_d;
    end
  end

  assign Imem_Req       = reset;
  assign Imem_Addr      = pc_q;
  assign PC             = pc_q;
  assign IF_Valid       = transfer & (state_q == FETCH) & ~sel_valid & ~PC_Stall;
  assign IF_PC          = reset ? (pc_q + 32'd4) : 32'h0;
  assign IF_Instruction = reset ? Imem_Rdata : 32'h0;
  assign IF_Busy        = reset & ((Imem_Req & ~Imem_Ready) | (state_q == DISCARD));

endmodule
`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h8000_0000, first fetch address after reset.
REQ-002 Parameter ILLOP_VECTOR, default 32'h8000_0004, interrupt entry address.
REQ-003 Parameter XADR_VECTOR, default 32'h8000_0008, exception entry address.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 PC_Stall  in  1  hazard-unit hold request; PC must not advance.
REQ-007 Jump, Jump_Target  in  1, 32  jump redirect from ID.
REQ-008 Branch_Taken, Branch_Target  in  1, 32  taken-branch redirect from EX.
REQ-009 Interrupt, Exception  in  1, 1  trap requests.
REQ-010 Imem_Req, Imem_Addr  out  1, 32  instruction-memory request and word address.
REQ-011 Imem_Ready, Imem_Rdata  in  1, 32  memory completion and read data, valid in the same cycle.
REQ-012 IF_PC, IF_Instruction, IF_Valid  out  32, 32, 1  fetched PC+4, instruction word, qualifier for the IF/ID register.
REQ-013 IF_Busy  out  1  fetch outstanding; downstream holds.
REQ-014 PC  out  32  current fetch address.

Function
REQ-015 Transfer = Imem_Req & Imem_Ready; Imem_Addr = PC, held stable while Imem_Req=1 and no transfer.
REQ-016 States FETCH and DISCARD; Imem_Req=1 in both whenever reset=1.
REQ-017 Redirect priority: Exception > Interrupt > Branch_Taken > Jump; target XADR_VECTOR, ILLOP_VECTOR, Branch_Target, Jump_Target.
REQ-018 Interrupt is ignored while PC[31]=1 (kernel mode); Exception is never ignored.
REQ-019 Targets have bits [1:0] forced to 0.
REQ-020 Sequential next PC = {PC[31], PC[30:0]+4}; bit 31 preserved; bits [30:0] wrap modulo 2^31.
REQ-021 FETCH, transfer, no redirect, PC_Stall=0: IF_Valid=1, IF_PC=PC+4, IF_Instruction=Imem_Rdata; PC <= sequential next PC.
REQ-022 FETCH, transfer, PC_Stall=1, no redirect: IF_Valid=0, PC holds; the same address is refetched.
REQ-023 FETCH, transfer, redirect in same cycle: IF_Valid=0 (wrong-path word dropped); PC <= target.
REQ-024 FETCH, no transfer, redirect: pending target registered; state -> DISCARD; PC and Imem_Addr unchanged.
REQ-025 DISCARD, no transfer: a new redirect overwrites the pending target, except that a pending Exception/Interrupt target is not overwritten by Branch/Jump.
REQ-026 DISCARD, transfer: IF_Valid=0; PC <= pending target, or a same-cycle redirect target if that redirect would win under REQ-025; state -> FETCH.
REQ-027 IF_Busy = Imem_Req & ~Imem_Ready, or state=DISCARD.
REQ-028 IF_Valid=0 whenever no transfer occurs; IF_PC and IF_Instruction are don't-care when IF_Valid=0.
REQ-029 With Imem_Ready tied 1: one instruction per cycle; zero-cycle latency from transfer to IF_* outputs.

Reset
REQ-030 While reset=0 at a clock edge: PC <= RESET_VECTOR, state <= FETCH, pending cleared.
REQ-031 While reset=0: Imem_Req=0, IF_Valid=0, IF_Busy=0, IF_PC=0, IF_Instruction=0.
REQ-032 First cycle after release: Imem_Req=1, Imem_Addr=32'h8000_0000.
REQ-033 Reset asserted mid-transfer or in DISCARD: in-flight data and pending target are discarded; no IF_Valid pulse.

Structure
REQ-034 Package if_pkg holds RESET_VECTOR/ILLOP_VECTOR/XADR_VECTOR defaults, the state enum {FETCH, DISCARD}, and the redirect-kind enum.
REQ-035 One combinational sub-module pc_redirect_sel applies the REQ-017/018/019 priority, masking and alignment; if_stage holds all state.

Verification
REQ-036 Reset release, Imem_Ready=1, Rdata=0x1111_0000+n -> Imem_Addr 0x8000_0000, _0004, _0008; IF_PC 0x8000_0004, _0008, _000C; IF_Valid=1 each cycle.
REQ-037 PC=0x0000_0100, PC_Stall=1 for 2 cycles -> Imem_Addr holds 0x100, IF_Valid=0; after release IF_PC=0x104.
REQ-038 Imem_Ready=0 for 3 cycles, Branch_Taken=1 to 0x0000_0200 in cycle 1 -> IF_Busy=1; ready-cycle word dropped; next Imem_Addr=0x200.
REQ-039 Jump to 0x300 and Exception in same cycle at PC=0x0000_0040 -> next PC=0x8000_0008; Interrupt at PC=0x8000_0010 -> ignored.
REQ-040 In DISCARD with pending Interrupt target, Branch_Taken to 0x400 -> ILLOP_VECTOR kept; reset mid-DISCARD -> PC=0x8000_0000, no IF_Valid.
